// File: rtl/cl_pkg.sv
// rtl/cl_pkg.sv - shared types and defaults for the Camera Link capture controller
// Purpose : FSM state encoding, default geometry widths, boolean constants.
// Ports   : none (package).
package cl_pkg;

  localparam int DEF_N_PORT = 10;
  localparam int DEF_COL_W  = 11;
  localparam int DEF_ROW_W  = 11;
  localparam int DEF_FRM_W  = 20;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    WAIT_FRM,
    FRAME
  } state_t;

endpackage

// File: rtl/cl_capture_ctrl_if.sv
// rtl/cl_capture_ctrl_if.sv - tagged pixel beat stream between capture controller and buffer writer
// Purpose : groups the pixel beat handshake and its frame/line tags.
// Ports   : master drives pix_valid/pix_data/pix_sof/pix_eol/pix_eof, samples pix_ready;
//           slave is the mirror image.
interface cl_capture_ctrl_if
  import cl_pkg::*;
#(
  parameter int DATA_W = 8 * DEF_N_PORT
);

  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_eof;
  logic              pix_ready;

  modport master (
    output pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );

endinterface

// File: rtl/cl_sync_edge.sv
// rtl/cl_sync_edge.sv - two-stage input register for fval/lval/data with edge strobes
// Purpose : registers the camera inputs once (d1), keeps the previous sample (d2),
//           and derives rise/fall strobes from d1/d2.
// Ports   : cl_z_pclk, reset (async, active-high); fval, lval, data in;
//           fval_d1, lval_d1, fval_d2, lval_d2, data_d2, fval_rise, fval_fall, lval_fall out.
module cl_sync_edge
  import cl_pkg::*;
#(
  parameter int DATA_W = 8 * DEF_N_PORT
)(
  input  logic              cl_z_pclk,
  input  logic              reset,
  input  logic              fval,
  input  logic              lval,
  input  logic [DATA_W-1:0] data,
  output logic              fval_d1,
  output logic              lval_d1,
  output logic              fval_d2,
  output logic              lval_d2,
  output logic [DATA_W-1:0] data_d2,
  output logic              fval_rise,
  output logic              fval_fall,
  output logic              lval_fall
);

  logic [DATA_W-1:0] data_d1;

  always_ff @(posedge cl_z_pclk or posedge reset) begin
    if (reset) begin
      fval_d1 <= FALSE;
      lval_d1 <= FALSE;
      fval_d2 <= FALSE;
      lval_d2 <= FALSE;
      data_d1 <= '0;
      data_d2 <= '0;
    end else begin
      fval_d1 <= fval;
      lval_d1 <= lval;
      data_d1 <= data;
      fval_d2 <= fval_d1;
      lval_d2 <= lval_d1;
      data_d2 <= data_d1;
    end
  end

  // d2 is the beat being presented downstream; d1 is its one-beat lookahead.
  assign fval_rise = fval_d1 & ~fval_d2;
  assign fval_fall = ~fval_d1 & fval_d2;
  assign lval_fall = ~lval_d1 & lval_d2;

endmodule

// File: rtl/cl_capture_ctrl.sv
// rtl/cl_capture_ctrl.sv - Camera Link frame-capture controller
// Purpose : arms on a host request, aligns to the next full frame, forwards N frames of
//           pixels as tagged beats and checks line length / row count against the armed geometry.
// Ports   : cl_z_pclk, reset (async, active-high); cl_fval, cl_z_lval, cl_data camera inputs;
//           cfg_n_col, cfg_n_row, arm_valid, arm_nfrm, arm_ready, stop host control;
//           pix (cl_capture_ctrl_if.master) beat stream; busy, frm_done, err_* status.
module cl_capture_ctrl
  import cl_pkg::*;
#(
  parameter int N_PORT = DEF_N_PORT,
  parameter int COL_W  = DEF_COL_W,
  parameter int ROW_W  = DEF_ROW_W,
  parameter int FRM_W  = DEF_FRM_W
)(
  input  logic                cl_z_pclk,
  input  logic                reset,
  input  logic                cl_fval,
  input  logic                cl_z_lval,
  input  logic [8*N_PORT-1:0] cl_data,
  input  logic [COL_W-1:0]    cfg_n_col,
  input  logic [ROW_W-1:0]    cfg_n_row,
  input  logic                arm_valid,
  input  logic [FRM_W-1:0]    arm_nfrm,
  output logic                arm_ready,
  input  logic                stop,
  cl_capture_ctrl_if.master   pix,
  output logic                busy,
  output logic [FRM_W-1:0]    frm_done,
  output logic                err_line,
  output logic                err_rows,
  output logic                err_ovf,
  output logic                err_sync
);

  logic                fval_d1, lval_d1, fval_d2, lval_d2;
  logic                fval_rise, fval_fall, lval_fall;
  logic [8*N_PORT-1:0] data_d2;

  state_t              state, state_nxt;
  logic [COL_W-1:0]    n_col_q, col, col_inc;
  logic [ROW_W-1:0]    n_row_q, row, row_inc, rows_final;
  logic [FRM_W-1:0]    nfrm_q;
  logic                stop_q, stop_seen, sof_pend;
  logic                arm_fire, beat, frame_end, last_frame;

  cl_sync_edge #(.DATA_W(8*N_PORT)) u_sync (
    .cl_z_pclk (cl_z_pclk),
    .reset     (reset),
    .fval      (cl_fval),
    .lval      (cl_z_lval),
    .data      (cl_data),
    .fval_d1   (fval_d1),
    .lval_d1   (lval_d1),
    .fval_d2   (fval_d2),
    .lval_d2   (lval_d2),
    .data_d2   (data_d2),
    .fval_rise (fval_rise),
    .fval_fall (fval_fall),
    .lval_fall (lval_fall)
  );

  assign arm_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign arm_fire  = arm_valid & arm_ready;
  assign stop_seen = stop_q | stop;

  // A beat is only emitted inside a frame; lval without fval never reaches the output.
  assign beat      = (state == FRAME) & fval_d2 & lval_d2;
  assign frame_end = (state == FRAME) & fval_fall;
  assign last_frame = stop_seen | ((nfrm_q != '0) && ((frm_done + 1'b1) == nfrm_q));

  assign col_inc    = (col == '1) ? col : col + 1'b1;
  assign row_inc    = (row == '1) ? row : row + 1'b1;
  // When fval and lval fall together the closing line has not been counted yet.
  assign rows_final = (beat & lval_fall) ? row_inc : row;

  // Output tags are combinational from the d2/d1 pair so reset clears pix_valid at once.
  assign pix.pix_valid = beat;
  assign pix.pix_data  = data_d2;
  assign pix.pix_sof   = beat & sof_pend;
  assign pix.pix_eol   = beat & lval_fall;
  assign pix.pix_eof   = beat & fval_fall;

  always_ff @(posedge cl_z_pclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (arm_fire) state_nxt = SYNC;
      SYNC:     if (stop_seen) state_nxt = IDLE;
                else if (!fval_d1) state_nxt = WAIT_FRM;
      WAIT_FRM: if (stop_seen) state_nxt = IDLE;
                else if (fval_rise) state_nxt = FRAME;
      FRAME:    if (frame_end) state_nxt = last_frame ? IDLE : WAIT_FRM;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cl_z_pclk or posedge reset) begin
    if (reset) begin
      n_col_q  <= '0;
      n_row_q  <= '0;
      nfrm_q   <= '0;
      col      <= '0;
      row      <= '0;
      frm_done <= '0;
      stop_q   <= FALSE;
      sof_pend <= FALSE;
      err_line <= FALSE;
      err_rows <= FALSE;
      err_ovf  <= FALSE;
      err_sync <= FALSE;
    end else begin
      // Stop is remembered until the FSM acts on it by returning to IDLE.
      stop_q <= (state_nxt == IDLE) ? FALSE : (stop_q | stop);

      if (arm_fire) begin
        n_col_q  <= cfg_n_col;
        n_row_q  <= cfg_n_row;
        nfrm_q   <= arm_nfrm;
        frm_done <= '0;
        err_line <= FALSE;
        err_rows <= FALSE;
        err_ovf  <= FALSE;
        err_sync <= FALSE;
      end

      if ((state == WAIT_FRM) && (state_nxt == FRAME)) begin
        col      <= '0;
        row      <= '0;
        sof_pend <= TRUE;
      end

      if (beat) begin
        sof_pend <= FALSE;
        if (lval_fall) begin
          if (col_inc != n_col_q) err_line <= TRUE;
          row <= row_inc;
          col <= '0;
        end else begin
          col <= col_inc;
        end
        // Camera cannot stall: a refused beat is lost but still counted for geometry.
        if (!pix.pix_ready) err_ovf <= TRUE;
      end

      if (frame_end) begin
        frm_done <= frm_done + 1'b1;
        if (rows_final != n_row_q) err_rows <= TRUE;
      end

      if ((state != IDLE) && lval_d1 && !fval_d1) err_sync <= TRUE;
    end
  end

endmodule
